// File: rtl/calc1.sv
// calc1: four independent arithmetic request ports.
// Each port takes a command plus operand 1 in one cycle and operand 2 in the next.
// It returns a one-cycle registered response three edges after the command.
// Vectors are numbered [0:W-1], with bit 0 as the MSB.

// calc1_port: one request port.
//   state   | meaning
//   IDLE    | waiting for a non-zero command; captures cmd and operand 1
//   OPND2   | captures operand 2 from data_in; cmd ignored
//   EXEC    | computes the result and response code; cmd ignored
//   RESP    | result is driven out on the following edge; cmd ignored
module calc1_port (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  cmd_in,
    input  logic [0:31] data_in,
    output logic [0:31] out_data,
    output logic [0:1]  out_resp
);
    typedef enum logic [1:0] {S_IDLE, S_OPND2, S_EXEC, S_RESP} state_t;

    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_OK   = 2'd1;
    localparam logic [0:1] RESP_ERR  = 2'd2;

    state_t      state_q, state_d;
    logic [0:3]  cmd_q, cmd_d;
    logic [0:31] op1_q, op1_d;
    logic [0:31] op2_q, op2_d;
    logic [0:31] res_data_q, res_data_d;
    logic [0:1]  res_code_q, res_code_d;
    logic [0:31] out_data_q, out_data_d;
    logic [0:1]  out_resp_q, out_resp_d;

    logic [32:0] sum33;
    logic [4:0]  shamt;

    assign sum33 = {1'b0, op1_q} + {1'b0, op2_q};
    assign shamt = op2_q[27:31];

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            res_data_q <= '0;
            res_code_q <= RESP_NONE;
            out_data_q <= '0;
            out_resp_q <= RESP_NONE;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            res_data_q <= res_data_d;
            res_code_q <= res_code_d;
            out_data_q <= out_data_d;
            out_resp_q <= out_resp_d;
        end
    end

    // Next-state logic: only IDLE looks at the command input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_in != 4'd0) state_d = S_OPND2;
            S_OPND2: state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, result computation and the one-cycle response pulse.
    always_comb begin
        cmd_d      = cmd_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        res_data_d = res_data_q;
        res_code_d = res_code_q;
        out_data_d = '0;
        out_resp_d = RESP_NONE;
        case (state_q)
            S_IDLE: begin
                if (cmd_in != 4'd0) begin
                    cmd_d = cmd_in;
                    op1_d = data_in;
                end
            end
            S_OPND2: op2_d = data_in;
            S_EXEC: begin
                res_data_d = '0;
                res_code_d = RESP_ERR;
                case (cmd_q)
                    4'd1: begin
                        if (!sum33[32]) begin
                            res_data_d = sum33[31:0];
                            res_code_d = RESP_OK;
                        end
                    end
                    4'd2: begin
                        if (op2_q <= op1_q) begin
                            res_data_d = op1_q - op2_q;
                            res_code_d = RESP_OK;
                        end
                    end
                    4'd5: begin
                        res_data_d = op1_q << shamt;
                        res_code_d = RESP_OK;
                    end
                    4'd6: begin
                        res_data_d = op1_q >> shamt;
                        res_code_d = RESP_OK;
                    end
                    default: begin
                        res_data_d = '0;
                        res_code_d = RESP_ERR;
                    end
                endcase
            end
            S_RESP: begin
                out_data_d = res_data_q;
                out_resp_d = res_code_q;
            end
            default: ;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        out_data = out_data_q;
        out_resp = out_resp_q;
    end
endmodule

// calc1: top level, four identical independent ports.
module calc1 (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    output logic [0:31] out_data1,
    output logic [0:1]  out_resp1,
    output logic [0:31] out_data2,
    output logic [0:1]  out_resp2,
    output logic [0:31] out_data3,
    output logic [0:1]  out_resp3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp4
);
    calc1_port u_port1 (.c_clk(c_clk), .reset(reset), .cmd_in(req1_cmd_in), .data_in(req1_data_in),
                        .out_data(out_data1), .out_resp(out_resp1));
    calc1_port u_port2 (.c_clk(c_clk), .reset(reset), .cmd_in(req2_cmd_in), .data_in(req2_data_in),
                        .out_data(out_data2), .out_resp(out_resp2));
    calc1_port u_port3 (.c_clk(c_clk), .reset(reset), .cmd_in(req3_cmd_in), .data_in(req3_data_in),
                        .out_data(out_data3), .out_resp(out_resp3));
    calc1_port u_port4 (.c_clk(c_clk), .reset(reset), .cmd_in(req4_cmd_in), .data_in(req4_data_in),
                        .out_data(out_data4), .out_resp(out_resp4));
endmodule

// File: tb/tb_calc1.sv
// Directed bench for calc1: hand-computed vectors, immediate-assertion checks.
module tb_calc1;
    logic        c_clk;
    logic        reset;
    logic [0:3]  cmd [4];
    logic [0:31] data [4];
    logic [0:31] odata [4];
    logic [0:1]  oresp [4];

    int errors = 0;
    int checks = 0;

    calc1 dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(cmd[0]), .req1_data_in(data[0]),
        .req2_cmd_in(cmd[1]), .req2_data_in(data[1]),
        .req3_cmd_in(cmd[2]), .req3_data_in(data[2]),
        .req4_cmd_in(cmd[3]), .req4_data_in(data[3]),
        .out_data1(odata[0]), .out_resp1(oresp[0]),
        .out_data2(odata[1]), .out_resp2(oresp[1]),
        .out_data3(odata[2]), .out_resp3(oresp[2]),
        .out_data4(odata[3]), .out_resp4(oresp[3])
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_idle(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s resp%0d", tag, i + 1), 32'(oresp[i]), 32'd0);
            chk($sformatf("%s data%0d", tag, i + 1), odata[i], 32'd0);
        end
    endtask

    // One request on port p; checks response timing and that other ports stay silent.
    task automatic run_op(input int p, input logic [0:3] c, input logic [0:31] a,
                          input logic [0:31] b, input logic [0:1] er, input logic [0:31] ed,
                          input string tag);
        @(negedge c_clk); cmd[p] = c; data[p] = a;
        @(posedge c_clk); #1 cmd[p] = 4'd0; data[p] = b;
        @(posedge c_clk); #1 data[p] = 32'd0;
        @(posedge c_clk); #1 chk({tag, " early resp"}, 32'(oresp[p]), 32'd0);
        @(posedge c_clk); #1;
        chk({tag, " resp"}, 32'(oresp[p]), 32'(er));
        chk({tag, " data"}, odata[p], ed);
        for (int i = 0; i < 4; i++)
            if (i != p) chk($sformatf("%s other resp%0d", tag, i + 1), 32'(oresp[i]), 32'd0);
        @(posedge c_clk); #1;
        chk({tag, " resp after"}, 32'(oresp[p]), 32'd0);
        chk({tag, " data after"}, odata[p], 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd[i] = 4'd0;
            data[i] = 32'd0;
        end
        #2 chk_all_idle("reset");
        repeat (3) @(posedge c_clk);
        @(negedge c_clk); reset = 1'b1;

        run_op(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, "add p1");
        run_op(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, "add ovf");
        run_op(2, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE, "add big");
        run_op(3, 4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000, "add zero");
        run_op(0, 4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E, "sub ok");
        run_op(1, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000, "sub neg");
        run_op(2, 4'd2, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000, "sub eq");
        run_op(3, 4'd5, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000, "shl 31");
        run_op(0, 4'd6, 32'h8000_0000, 32'h0000_0021, 2'd1, 32'h4000_0000, "shr 1");
        run_op(1, 4'd5, 32'h0000_1234, 32'hFFFF_FFE0, 2'd1, 32'h0000_1234, "shl 0");
        run_op(2, 4'd6, 32'hA5A5_0000, 32'h0000_0000, 2'd1, 32'hA5A5_0000, "shr 0");
        run_op(3, 4'd5, 32'h0000_00F0, 32'h0000_0004, 2'd1, 32'h0000_0F00, "shl 4");
        run_op(0, 4'd3, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000, "inv 3");
        run_op(1, 4'd4, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000, "inv 4");
        run_op(2, 4'd15, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000, "inv 15");

        // Commands presented while busy must be ignored.
        @(negedge c_clk); cmd[0] = 4'd1; data[0] = 32'd2;
        @(posedge c_clk); #1 cmd[0] = 4'd2; data[0] = 32'd3;
        @(posedge c_clk); #1 cmd[0] = 4'd1; data[0] = 32'h100;
        @(posedge c_clk); #1 cmd[0] = 4'd0; data[0] = 32'd0;
        chk("busy early resp", 32'(oresp[0]), 32'd0);
        @(posedge c_clk); #1;
        chk("busy resp", 32'(oresp[0]), 32'd1);
        chk("busy data", odata[0], 32'd5);
        for (int k = 0; k < 4; k++) begin
            @(posedge c_clk); #1;
            chk($sformatf("busy no extra resp c%0d", k), 32'(oresp[0]), 32'd0);
        end

        // All four ports in the same cycle.
        @(negedge c_clk);
        for (int i = 0; i < 4; i++) begin cmd[i] = 4'd1; data[i] = 32'(i + 1); end
        @(posedge c_clk); #1;
        for (int i = 0; i < 4; i++) begin cmd[i] = 4'd0; data[i] = 32'h10 * 32'(i + 1); end
        @(posedge c_clk); #1;
        for (int i = 0; i < 4; i++) data[i] = 32'd0;
        @(posedge c_clk); #1 chk_all_idle("par early");
        @(posedge c_clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("par resp%0d", i + 1), 32'(oresp[i]), 32'd1);
            chk($sformatf("par data%0d", i + 1), odata[i], 32'h11 * 32'(i + 1));
        end
        // Reset while a response is visible clears outputs immediately.
        reset = 1'b0;
        #1 chk_all_idle("async clr");
        @(negedge c_clk); reset = 1'b1;

        // Reset mid-request: no response may follow.
        @(negedge c_clk);
        for (int i = 0; i < 4; i++) begin cmd[i] = 4'd1; data[i] = 32'd7; end
        @(posedge c_clk); #1;
        for (int i = 0; i < 4; i++) begin cmd[i] = 4'd0; data[i] = 32'd9; end
        @(posedge c_clk); #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) data[i] = 32'd0;
        #1 chk_all_idle("mid rst");
        @(negedge c_clk); reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge c_clk); #1 chk_all_idle($sformatf("post rst c%0d", k));
        end

        // First edge after reset release captures a command.
        @(negedge c_clk); reset = 1'b0;
        @(negedge c_clk);
        cmd[3] = 4'd1; data[3] = 32'h0000_0100;
        reset = 1'b1;
        @(posedge c_clk); #1 cmd[3] = 4'd0; data[3] = 32'h0000_0023;
        @(posedge c_clk); #1 data[3] = 32'd0;
        @(posedge c_clk); #1 chk("first edge early", 32'(oresp[3]), 32'd0);
        @(posedge c_clk); #1;
        chk("first edge resp", 32'(oresp[3]), 32'd1);
        chk("first edge data", odata[3], 32'h0000_0123);

        repeat (2) @(posedge c_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
